mm_peripheral_router: RTL and testbench

MM_PERIPHERAL_ROUTER -- requirements
Module: mm_peripheral_router

---
 rtl/mm_bus_pkg.sv | 15 +
 rtl/mm_addr_decode.sv | 29 ++
 rtl/mm_peripheral_router.sv | 191 +++++++++++++++++++
 tb/tb_mm_peripheral_router.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_bus_pkg.sv
// Shared definitions for the memory-mapped peripheral router: FSM state
// encoding and the read data returned on any bus error.
package mm_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // All-ones pattern; users take the low DATA_W bits.
  localparam logic [255:0] BUS_ERR_DATA = '1;

endpackage

// File: rtl/mm_addr_decode.sv
// Combinational address decoder: maps a controller address onto a
// peripheral index and the offset inside that peripheral's region.
module mm_addr_decode #(
  parameter int                unsigned ADDR_W      = 32,
  parameter int                unsigned N_PERIPH    = 4,
  parameter int                unsigned REGION_BITS = 12,
  parameter logic [ADDR_W-1:0]          BASE_ADDR   = 32'h4000_0000,
  parameter int                unsigned IDX_W       = 2
) (
  input  logic [ADDR_W-1:0]      addr_i,
  output logic                   hit_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic [REGION_BITS-1:0] offset_o
);

  logic [ADDR_W-1:0] diff;
  logic [ADDR_W-1:0] idx_full;

  // Hit only when the address is at or above the base (no underflow) and
  // the full-width region index lands on an existing port.
  always_comb begin
    diff     = addr_i - BASE_ADDR;
    idx_full = diff >> REGION_BITS;
    hit_o    = (addr_i >= BASE_ADDR) && (idx_full < ADDR_W'(N_PERIPH));
    idx_o    = idx_full[IDX_W-1:0];
    offset_o = diff[REGION_BITS-1:0];
  end

endmodule

// File: rtl/mm_peripheral_router.sv
// Memory-mapped router: one controller port fanned out to N_PERIPH
// peripheral ports, one outstanding transaction at a time.
// Optional build macro MM_ROUTER_TIMEOUT_EN adds a WAIT-state watchdog.
//
// Handshake: the controller holds ReadAssert or WriteAssert (with address
// and write data stable) until ReadOK/WriteOK pulses for one cycle, then
// must drop its assert before another transaction is accepted. Towards a
// peripheral, exactly one P*Assert bit is held until that port answers with
// the OK of the same direction; every other peripheral OK is ignored.
module mm_peripheral_router
  import mm_bus_pkg::*;
#(
  parameter int                unsigned ADDR_W         = 32,
  parameter int                unsigned DATA_W         = 32,
  parameter int                unsigned N_PERIPH       = 4,
  parameter int                unsigned REGION_BITS    = 12,
  parameter logic [ADDR_W-1:0]          BASE_ADDR      = 32'h4000_0000,
  parameter int                unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             Clock,
  input  logic                             Reset_n,
  // controller side
  input  logic [ADDR_W-1:0]                AddressBus,
  input  logic [DATA_W-1:0]                DataWriteBus,
  output logic [DATA_W-1:0]                DataReadBus,
  input  logic                             WriteAssert,
  input  logic                             ReadAssert,
  output logic                             WriteOK,
  output logic                             ReadOK,
  output logic                             BusError,
  // peripheral side
  output logic [REGION_BITS-1:0]           PAddressBus,
  output logic [DATA_W-1:0]                PDataWriteBus,
  input  logic [N_PERIPH-1:0][DATA_W-1:0]  PDataReadBus,
  output logic [N_PERIPH-1:0]              PWriteAssert,
  output logic [N_PERIPH-1:0]              PReadAssert,
  input  logic [N_PERIPH-1:0]              PWriteOK,
  input  logic [N_PERIPH-1:0]              PReadOK,
  // debug
  output state_t                           DbgState
);

  localparam int unsigned IDX_W = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;

  state_t                 state_q, state_d;
  logic [REGION_BITS-1:0] paddr_q;
  logic [DATA_W-1:0]      pwdata_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [IDX_W-1:0]       sel_q;
  logic                   dir_rd_q;
  logic                   err_q;

  logic                   dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic [REGION_BITS-1:0] dec_offset;

  logic                   periph_ok;
  logic                   tmo_hit;
  logic                   start_hit;
  logic                   start_err;
  logic                   done_ok;
  logic                   done_tmo;
  logic [N_PERIPH-1:0]    sel_oh;

  mm_addr_decode #(
    .ADDR_W      (ADDR_W),
    .N_PERIPH    (N_PERIPH),
    .REGION_BITS (REGION_BITS),
    .BASE_ADDR   (BASE_ADDR),
    .IDX_W       (IDX_W)
  ) u_decode (
    .addr_i   (AddressBus),
    .hit_o    (dec_hit),
    .idx_o    (dec_idx),
    .offset_o (dec_offset)
  );

  // Only the selected port's OK in the registered direction counts.
  assign periph_ok = dir_rd_q ? PReadOK[sel_q] : PWriteOK[sel_q];
  assign sel_oh    = N_PERIPH'(1) << sel_q;

`ifdef MM_ROUTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Watchdog counts WAIT cycles without an answer; cleared everywhere else.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (state_q == ST_WAIT && !periph_ok && !tmo_hit) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: WAIT lasts until the peripheral answers.
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic plus one-cycle event strobes for the datapath.
  always_comb begin
    state_d   = state_q;
    start_hit = 1'b0;
    start_err = 1'b0;
    done_ok   = 1'b0;
    done_tmo  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ReadAssert || WriteAssert) begin
          if ((ReadAssert && WriteAssert) || !dec_hit) begin
            start_err = 1'b1;
            state_d   = ST_RESPOND;
          end else begin
            start_hit = 1'b1;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (periph_ok) begin
          done_ok = 1'b1;
          state_d = ST_RESPOND;
        end else if (tmo_hit) begin
          done_tmo = 1'b1;
          state_d  = ST_RESPOND;
        end
      end
      ST_RESPOND: state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!ReadAssert && !WriteAssert) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction registers; read data changes only on capture or error.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      sel_q    <= '0;
      dir_rd_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (start_hit) begin
        paddr_q  <= dec_offset;
        pwdata_q <= DataWriteBus;
        sel_q    <= dec_idx;
        dir_rd_q <= ReadAssert;
        err_q    <= 1'b0;
      end
      if (start_err) begin
        // Both asserts high reports as a read.
        dir_rd_q <= ReadAssert;
        err_q    <= 1'b1;
        rdata_q  <= BUS_ERR_DATA[DATA_W-1:0];
      end
      if (done_ok && dir_rd_q) begin
        rdata_q <= PDataReadBus[sel_q];
      end
      if (done_tmo) begin
        err_q   <= 1'b1;
        rdata_q <= BUS_ERR_DATA[DATA_W-1:0];
      end
    end
  end

  // Outputs decoded from the current state and transaction registers.
  always_comb begin
    PReadAssert   = (state_q == ST_WAIT &&  dir_rd_q) ? sel_oh : '0;
    PWriteAssert  = (state_q == ST_WAIT && !dir_rd_q) ? sel_oh : '0;
    ReadOK        = (state_q == ST_RESPOND) &&  dir_rd_q;
    WriteOK       = (state_q == ST_RESPOND) && !dir_rd_q;
    BusError      = (state_q == ST_RESPOND) &&  err_q;
    DataReadBus   = rdata_q;
    PAddressBus   = paddr_q;
    PDataWriteBus = pwdata_q;
    DbgState      = state_q;
  end

endmodule

// File: tb/tb_mm_peripheral_router.sv
// Directed bench for mm_peripheral_router (4 ports, 4 KiB regions at
// 0x4000_0000). Build with MM_ROUTER_TIMEOUT_EN to add the watchdog case.
module tb_mm_peripheral_router;
  import mm_bus_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [31:0]       AddressBus;
  logic [31:0]       DataWriteBus;
  logic [31:0]       DataReadBus;
  logic              WriteAssert;
  logic              ReadAssert;
  logic              WriteOK;
  logic              ReadOK;
  logic              BusError;
  logic [11:0]       PAddressBus;
  logic [31:0]       PDataWriteBus;
  logic [3:0][31:0]  PDataReadBus;
  logic [3:0]        PWriteAssert;
  logic [3:0]        PReadAssert;
  logic [3:0]        PWriteOK;
  logic [3:0]        PReadOK;
  state_t            DbgState;

  int                n_vec  = 0;
  int                n_miss = 0;
  logic [32:0]       exp_q[$];
  logic [31:0]       last_rd;

  mm_peripheral_router #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .N_PERIPH       (4),
    .REGION_BITS    (12),
    .BASE_ADDR      (32'h4000_0000),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .Clock         (clk),
    .Reset_n       (rst_n),
    .AddressBus    (AddressBus),
    .DataWriteBus  (DataWriteBus),
    .DataReadBus   (DataReadBus),
    .WriteAssert   (WriteAssert),
    .ReadAssert    (ReadAssert),
    .WriteOK       (WriteOK),
    .ReadOK        (ReadOK),
    .BusError      (BusError),
    .PAddressBus   (PAddressBus),
    .PDataWriteBus (PDataWriteBus),
    .PDataReadBus  (PDataReadBus),
    .PWriteAssert  (PWriteAssert),
    .PReadAssert   (PReadAssert),
    .PWriteOK      (PWriteOK),
    .PReadOK       (PReadOK),
    .DbgState      (DbgState)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: read answered by port after lat cycles, optional hold in RELEASE
  task automatic do_read(input logic [31:0] addr, input int port, input int lat,
                         input logic [31:0] data, input int hold);
    exp_q.push_back({1'b0, data});
    AddressBus = addr;
    ReadAssert = 1'b1;
    @(negedge clk);
    check("rd_passert", PReadAssert, 4'b0001 << port);
    check("rd_paddr", PAddressBus, {52'd0, addr[11:0]});
    repeat (lat - 1) @(negedge clk);
    check("rd_passert_held", PReadAssert, 4'b0001 << port);
    PReadOK[port]      = 1'b1;
    PDataReadBus[port] = data;
    @(negedge clk);
    PReadOK = '0;
    check("rd_ok", {ReadOK, WriteOK}, 2'b10);
    check("rd_data", {BusError, DataReadBus}, exp_q.pop_front());
    check("rd_passert_drop", PReadAssert, 4'b0000);
    last_rd = data;
    // leave a different valid address on the bus while held
    AddressBus = 32'h4000_1000;
    for (int i = 0; i < hold + 1; i++) begin
      @(negedge clk);
      check("rd_release_quiet", {ReadOK, PReadAssert, PWriteAssert}, 9'd0);
    end
    if (hold > 0) check("rd_release_state", DbgState, ST_RELEASE);
    ReadAssert = 1'b0;
    @(negedge clk);
    check("rd_back_idle", DbgState, ST_IDLE);
  endtask

  // driver: write acknowledged by port one cycle after assert
  task automatic do_write(input logic [31:0] addr, input int port, input logic [31:0] data);
    exp_q.push_back({1'b0, last_rd});
    AddressBus   = addr;
    DataWriteBus = data;
    WriteAssert  = 1'b1;
    @(negedge clk);
    check("wr_passert", {PWriteAssert, PReadAssert}, {4'b0001 << port, 4'b0000});
    check("wr_pdata", PDataWriteBus, data);
    check("wr_paddr", PAddressBus, {52'd0, addr[11:0]});
    PWriteOK[port] = 1'b1;
    @(negedge clk);
    PWriteOK = '0;
    check("wr_ok", {WriteOK, ReadOK}, 2'b10);
    check("wr_err_data", {BusError, DataReadBus}, exp_q.pop_front());
    @(negedge clk);
    check("wr_ok_pulse", WriteOK, 1'b0);
    WriteAssert = 1'b0;
    @(negedge clk);
  endtask

  // driver: decode error (unmapped or both asserts)
  task automatic do_err(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic exp_rd);
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});
    AddressBus  = addr;
    ReadAssert  = rd;
    WriteAssert = wr;
    @(negedge clk);
    check({tag, "_noassert"}, {PReadAssert, PWriteAssert}, 8'd0);
    check({tag, "_ok"}, {ReadOK, WriteOK}, {exp_rd, ~exp_rd});
    check({tag, "_data"}, {BusError, DataReadBus}, exp_q.pop_front());
    last_rd = 32'hFFFF_FFFF;
    @(negedge clk);
    check({tag, "_pulse"}, {ReadOK, WriteOK, BusError}, 3'd0);
    ReadAssert  = 1'b0;
    WriteAssert = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    AddressBus   = '0;
    DataWriteBus = '0;
    ReadAssert   = 1'b0;
    WriteAssert  = 1'b0;
    PDataReadBus = '0;
    PReadOK      = '0;
    PWriteOK     = '0;
    last_rd      = '0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {PReadAssert, PWriteAssert, ReadOK, WriteOK, BusError}, 11'd0);
    check("rst_buses", {DataReadBus, PAddressBus, PDataWriteBus}, 76'd0);
    check("rst_state", DbgState, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // basic read / write / unmapped
    do_read(32'h4000_2010, 2, 3, 32'hCAFE_F00D, 0);
    do_write(32'h4000_0004, 0, 32'h1234_5678);
    do_err("unmapped", 1'b1, 1'b0, 32'h4000_4000, 1'b1);
    do_err("underflow", 1'b1, 1'b0, 32'h3FFF_FFFC, 1'b1);
    do_err("both", 1'b1, 1'b1, 32'h4000_1000, 1'b1);
    do_err("wr_unmapped", 1'b0, 1'b1, 32'h8000_0000, 1'b0);
    do_read(32'h4000_3FFC, 3, 1, 32'hA5A5_0001, 0);

    // stray OKs in IDLE change nothing
    PReadOK  = 4'hF;
    PWriteOK = 4'hF;
    PDataReadBus = {4{32'h5555_5555}};
    @(negedge clk);
    check("stray_idle", {ReadOK, WriteOK, BusError, DataReadBus}, {3'd0, last_rd});
    check("stray_idle_state", DbgState, ST_IDLE);
    PReadOK  = '0;
    PWriteOK = '0;

    // wrong-port and wrong-direction OKs during WAIT are ignored
    AddressBus = 32'h4000_2020;
    ReadAssert = 1'b1;
    @(negedge clk);
    PReadOK[1]  = 1'b1;
    PWriteOK[2] = 1'b1;
    PDataReadBus[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    PReadOK  = '0;
    PWriteOK = '0;
    check("stray_wait_held", {ReadOK, PReadAssert}, 5'b0_0100);
    check("stray_wait_state", DbgState, ST_WAIT);
    PReadOK[2] = 1'b1;
    PDataReadBus[2] = 32'h0000_600D;
    @(negedge clk);
    PReadOK = '0;
    check("stray_wait_resp", {ReadOK, BusError, DataReadBus}, {2'b10, 32'h0000_600D});
    last_rd = 32'h0000_600D;
    @(negedge clk);
    ReadAssert = 1'b0;
    @(negedge clk);

    // ReadAssert held 5 cycles after ReadOK: no second transaction
    do_read(32'h4000_0100, 0, 2, 32'h0BAD_CAFE, 5);

    // reset in WAIT aborts without any OK
    AddressBus = 32'h4000_3008;
    ReadAssert = 1'b1;
    @(negedge clk);
    check("rstw_pre", PReadAssert, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_asserts", {PReadAssert, PWriteAssert, ReadOK, WriteOK, BusError}, 11'd0);
    check("rstw_buses", {DataReadBus, PAddressBus, PDataWriteBus}, 76'd0);
    check("rstw_state", DbgState, ST_IDLE);
    last_rd = '0;
    ReadAssert = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rstw_after", {ReadOK, WriteOK, PReadAssert}, 6'd0);

`ifdef MM_ROUTER_TIMEOUT_EN
    // silent port 1: assert held 8 cycles, then error response
    AddressBus = 32'h4000_1040;
    ReadAssert = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("tmo_held", {ReadOK, PReadAssert}, 5'b0_0010);
    end
    @(negedge clk);
    check("tmo_drop", PReadAssert, 4'b0000);
    check("tmo_resp", {ReadOK, BusError, DataReadBus}, {2'b11, 32'hFFFF_FFFF});
    @(negedge clk);
    ReadAssert = 1'b0;
    @(negedge clk);
`endif

    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
